// File: rtl/disp_pkg.sv
// Shared definitions for the 7-segment display scan controller.
// Optional feature macro used by disp_scan_ctrl: DISP_LZB_EN (leading-zero blanking).
package disp_pkg;

  // Per-digit scan phases: dark gap, decoder settle, digit lit.
  typedef enum logic [1:0] {
    ST_BLANK = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHOW  = 2'd2
  } scan_state_e;

  // Largest code the decoder renders as a real digit.
  localparam logic [3:0] BCD_MAX = 4'd9;

  // Anode-off pattern (common-anode, active-low selects); sliced to DIGITS.
  localparam logic [7:0] ANODE_OFF = 8'hFF;

  // Larger of two integers, used for sizing the phase timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/disp_scan_ctrl_scan_timer.sv
// Loadable down-counter for the scan phases. tc_o is high while the count is
// zero, i.e. during the last cycle of a phase loaded with (length-1).
module scan_timer #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         n_rst_i,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt;

  // Clear has priority over load; otherwise count down and stop at zero.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      cnt <= '0;
    end else if (clr_i) begin
      cnt <= '0;
    end else if (load_i) begin
      cnt <= load_val_i;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign tc_o = (cnt == '0);

endmodule

// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed scan controller for a DIGITS-wide common-anode 7-segment
// display sharing one registered (1-cycle) BCD decoder.
// Each digit slot is BLANK (GAP_CYC) -> SETUP (1) -> SHOW (ON_CYC). The code
// changes only when entering SETUP, so the decoder output is settled for the
// whole SHOW phase. Display data is double-buffered and swapped only at the
// frame boundary so a frame never mixes old and new values.
// Optional macro DISP_LZB_EN: blank leading zeros (digit 0 always shown).
// The timer is cleared on reset/disable, so the first gap after either is a
// single cycle; the display was already dark, so no ghosting can result.
module disp_scan_ctrl
  import disp_pkg::*;
#(
  parameter int DIGITS  = 4,
  parameter int ON_CYC  = 50000,
  parameter int GAP_CYC = 500
) (
  input  logic                  clk_i,
  input  logic                  n_rst_i,
  input  logic                  en_i,
  input  logic                  load_i,
  input  logic [4*DIGITS-1:0]   bcd_i,
  output logic [3:0]            dig_code_o,
  output logic [DIGITS-1:0]     dig_sel_o,
  output logic                  frame_done_o
);

  localparam int TW = $clog2(max_int(ON_CYC, GAP_CYC) + 1);
  localparam int IW = $clog2(DIGITS);

  localparam logic [TW-1:0]     ON_LOAD  = TW'(ON_CYC - 1);
  localparam logic [TW-1:0]     GAP_LOAD = TW'(GAP_CYC - 1);
  localparam logic [IW-1:0]     IDX_LAST = IW'(DIGITS - 1);
  localparam logic [DIGITS-1:0] SEL_OFF  = ANODE_OFF[DIGITS-1:0];

  scan_state_e         state;
  logic [IW-1:0]       idx;
  logic [4*DIGITS-1:0] active_buf;
  logic [4*DIGITS-1:0] pending_buf;
  logic                pending_flag;

  logic                tc;
  logic                t_clr;
  logic                t_load;
  logic [TW-1:0]       t_val;
  logic                frame_end;
  logic [3:0]          cur_digit;
  logic                digit_blank;

  // Phase timer shared by all three states.
  scan_timer #(.W(TW)) u_timer (
    .clk_i      (clk_i),
    .n_rst_i    (n_rst_i),
    .clr_i      (t_clr),
    .load_i     (t_load),
    .load_val_i (t_val),
    .tc_o       (tc)
  );

  // Last cycle of the SHOW phase of the highest digit: the frame boundary.
  assign frame_end = en_i && (state == ST_SHOW) && tc && (idx == IDX_LAST);

  // Select the active-buffer nibble for the current digit index.
  always_comb begin
    cur_digit = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx) cur_digit = active_buf[i*4 +: 4];
    end
  end

  // Decide at SETUP whether this digit stays dark (invalid code, or a leading zero).
  always_comb begin
    digit_blank = (cur_digit > BCD_MAX);
`ifdef DISP_LZB_EN
    begin
      logic nz_from_idx;
      nz_from_idx = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
        if ((IW'(i) >= idx) && (active_buf[i*4 +: 4] != 4'd0)) nz_from_idx = 1'b1;
      end
      if ((idx != '0) && !nz_from_idx) digit_blank = 1'b1;
    end
`endif
  end

  // Timer reload on every state change; cleared while disabled.
  always_comb begin
    t_clr  = !en_i;
    t_load = 1'b0;
    t_val  = '0;
    if (en_i) begin
      case (state)
        ST_BLANK: begin
          t_load = tc;
          t_val  = '0;
        end
        ST_SETUP: begin
          t_load = 1'b1;
          t_val  = ON_LOAD;
        end
        ST_SHOW: begin
          t_load = tc;
          t_val  = GAP_LOAD;
        end
        default: begin
          t_load = 1'b1;
          t_val  = '0;
        end
      endcase
    end
  end

  // Scan FSM with registered outputs aligned to the state they belong to.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      state        <= ST_BLANK;
      idx          <= '0;
      dig_code_o   <= 4'd0;
      dig_sel_o    <= SEL_OFF;
      frame_done_o <= 1'b0;
    end else begin
      frame_done_o <= 1'b0;
      if (!en_i) begin
        state     <= ST_BLANK;
        idx       <= '0;
        dig_sel_o <= SEL_OFF;
      end else begin
        case (state)
          ST_BLANK: begin
            if (tc) begin
              state      <= ST_SETUP;
              dig_code_o <= cur_digit;
            end
          end
          ST_SETUP: begin
            state     <= ST_SHOW;
            dig_sel_o <= digit_blank ? SEL_OFF : ~(DIGITS'(1) << idx);
          end
          ST_SHOW: begin
            if (tc) begin
              state        <= ST_BLANK;
              dig_sel_o    <= SEL_OFF;
              frame_done_o <= (idx == IDX_LAST);
              idx          <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
          end
          default: begin
            state     <= ST_BLANK;
            dig_sel_o <= SEL_OFF;
          end
        endcase
      end
    end
  end

  // Double buffer: loads land in pending; pending moves to active at the frame
  // boundary or at once while disabled. A load on the swap cycle goes direct.
  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      active_buf   <= '0;
      pending_buf  <= '0;
      pending_flag <= 1'b0;
    end else if (load_i) begin
      pending_buf <= bcd_i;
      if (frame_end || !en_i) begin
        active_buf   <= bcd_i;
        pending_flag <= 1'b0;
      end else begin
        pending_flag <= 1'b1;
      end
    end else if ((frame_end || !en_i) && pending_flag) begin
      active_buf   <= pending_buf;
      pending_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Directed bench for disp_scan_ctrl with DIGITS=4, ON_CYC=4, GAP_CYC=1.
// A frame is 24 cycles; cycle k of a frame has slot k/6 and phase k%6:
// phase 0 BLANK, 1 SETUP (new code), 2..5 SHOW (anode low if the digit is lit).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_disp_scan_ctrl;

  localparam int DIGITS  = 4;
  localparam int ON_CYC  = 4;
  localparam int GAP_CYC = 1;

`ifdef DISP_LZB_EN
  localparam logic [3:0] LIT_0042 = 4'b0011;
  localparam logic [3:0] LIT_0000 = 4'b0001;
`else
  localparam logic [3:0] LIT_0042 = 4'b1111;
  localparam logic [3:0] LIT_0000 = 4'b1111;
`endif

  logic        clk_i = 1'b0;
  logic        n_rst_i;
  logic        en_i;
  logic        load_i;
  logic [15:0] bcd_i;
  logic [3:0]  dig_code_o;
  logic [3:0]  dig_sel_o;
  logic        frame_done_o;

  int n_cmp;
  int n_err;

  disp_scan_ctrl #(
    .DIGITS  (DIGITS),
    .ON_CYC  (ON_CYC),
    .GAP_CYC (GAP_CYC)
  ) dut (
    .clk_i        (clk_i),
    .n_rst_i      (n_rst_i),
    .en_i         (en_i),
    .load_i       (load_i),
    .bcd_i        (bcd_i),
    .dig_code_o   (dig_code_o),
    .dig_sel_o    (dig_sel_o),
    .frame_done_o (frame_done_o)
  );

  // Clock
  always #5 clk_i = ~clk_i;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "bench timeout");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected outputs for cycle k of a frame showing val with lit-digit mask lit.
  task automatic check_cycle(input string tag, input int k, input logic [15:0] val,
                             input logic [3:0] lit, input bit fd_first);
    int         slot;
    int         ph;
    logic [3:0] exp_sel;
    slot    = k / 6;
    ph      = k % 6;
    exp_sel = 4'hF;
    if (ph >= 2 && lit[slot]) exp_sel[slot] = 1'b0;
    check($sformatf("%s sel k%0d", tag, k), 16'(dig_sel_o), 16'(exp_sel));
    if (ph >= 1)
      check($sformatf("%s code k%0d", tag, k), 16'(dig_code_o), 16'(val[slot*4 +: 4]));
    check($sformatf("%s fd k%0d", tag, k), 16'(frame_done_o), 16'((k == 0) && fd_first));
  endtask

  // Whole frame; cycle 0 is checked at the current falling edge. Optional loads
  // are driven at frame cycles lk0 and lk1 (-1 = none).
  task automatic check_frame(input string tag, input logic [15:0] val, input logic [3:0] lit,
                             input bit fd_first, input int lk0, input logic [15:0] lv0,
                             input int lk1, input logic [15:0] lv1);
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clk_i);
      check_cycle(tag, k, val, lit, fd_first);
      load_i = (k == lk0) || (k == lk1);
      bcd_i  = (k == lk1) ? lv1 : lv0;
    end
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    n_rst_i = 1'b0;
    en_i    = 1'b0;
    load_i  = 1'b0;
    bcd_i   = 16'h0;

    // Reset state
    repeat (3) @(negedge clk_i);
    check("rst sel", 16'(dig_sel_o), 16'hF);
    check("rst code", 16'(dig_code_o), 16'h0);
    check("rst fd", 16'(frame_done_o), 16'h0);
    n_rst_i = 1'b1;

    // Load while disabled goes straight to active, then enable
    @(negedge clk_i);
    load_i = 1'b1;
    bcd_i  = 16'h1234;
    @(negedge clk_i);
    load_i = 1'b0;
    en_i   = 1'b1;
    check_frame("f1", 16'h1234, 4'b1111, 1'b0, -1, 16'h0, -1, 16'h0);

    // Mid-frame load waits for the boundary
    @(negedge clk_i);
    check_frame("f2", 16'h1234, 4'b1111, 1'b1, 10, 16'h5678, -1, 16'h0);
    // Load on the boundary cycle applies to the next frame
    @(negedge clk_i);
    check_frame("f3", 16'h5678, 4'b1111, 1'b1, 23, 16'h8765, -1, 16'h0);
    // Two loads in a frame: last one wins
    @(negedge clk_i);
    check_frame("f4", 16'h8765, 4'b1111, 1'b1, 5, 16'h1111, 15, 16'h3579);
    @(negedge clk_i);
    check_frame("f5", 16'h3579, 4'b1111, 1'b1, 23, 16'h12A4, -1, 16'h0);
    // Invalid code on digit 1 keeps its anode off; timing unchanged
    @(negedge clk_i);
    check_frame("f6", 16'h12A4, 4'b1101, 1'b1, 23, 16'h0042, -1, 16'h0);
    // Leading zeros
    @(negedge clk_i);
    check_frame("f7", 16'h0042, LIT_0042, 1'b1, 23, 16'h0000, -1, 16'h0);
    @(negedge clk_i);
    check_frame("f8", 16'h0000, LIT_0000, 1'b1, 23, 16'h4321, -1, 16'h0);

    // Drop enable mid-SHOW of digit 2 with a value pending
    @(negedge clk_i);
    for (int k = 0; k <= 14; k++) begin
      if (k > 0) @(negedge clk_i);
      check_cycle("f9", k, 16'h4321, 4'b1111, 1'b1);
      load_i = (k == 3);
      bcd_i  = 16'h9876;
      if (k == 14) en_i = 1'b0;
    end
    for (int j = 0; j < 3; j++) begin
      @(negedge clk_i);
      check($sformatf("dis sel %0d", j), 16'(dig_sel_o), 16'hF);
      check($sformatf("dis fd %0d", j), 16'(frame_done_o), 16'h0);
    end
    // Re-enable: scan restarts at digit 0 with the pending value now active
    en_i = 1'b1;
    check_frame("f10", 16'h9876, 4'b1111, 1'b0, -1, 16'h0, -1, 16'h0);

    // Asynchronous reset mid-SHOW of digit 2
    @(negedge clk_i);
    for (int k = 0; k <= 15; k++) begin
      if (k > 0) @(negedge clk_i);
      check_cycle("f11", k, 16'h9876, 4'b1111, 1'b1);
    end
    #3;
    n_rst_i = 1'b0;
    en_i    = 1'b0;
    #1;
    check("arst sel", 16'(dig_sel_o), 16'hF);
    check("arst code", 16'(dig_code_o), 16'h0);
    check("arst fd", 16'(frame_done_o), 16'h0);
    @(negedge clk_i);
    n_rst_i = 1'b1;
    @(negedge clk_i);
    en_i = 1'b1;
    check_frame("f12", 16'h0000, LIT_0000, 1'b0, -1, 16'h0, -1, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
